// File: rtl/census_match_engine.sv
// Census-transform and Hamming disparity match engine, attached as a multi-cycle Nios II custom instruction.
// Optional feature macro: CENSUS_THRESH_EN (saturating noise threshold from iB in the census compare).
module census_match_engine #(
   parameter int WIN   = 11,
   parameter int PIX_W = 8,
   parameter int DEPTH = 16,
   parameter int CHUNK = 32
) (
   input  logic        iClk,
   input  logic        iReset,
   input  logic        iClk_en,
   input  logic        iStart,
   input  logic [3:0]  iOp,
   input  logic [31:0] iA,
   input  logic [31:0] iB,
   output logic [31:0] oRes,
   output logic        oDone
);

   localparam int N        = WIN * WIN;
   localparam int CODE_W   = N - 1;
   localparam int HALF     = CODE_W / 2;
   localparam int NCH      = (CODE_W + CHUNK - 1) / CHUNK;
   localparam int SCAN_W   = NCH * CHUNK;
   localparam int PP64     = 64 / PIX_W;
   localparam int PP32     = 32 / PIX_W;
   localparam int NP_W     = $clog2(PP32 + 1);
   localparam int ACC_W    = $clog2(CODE_W + 1);
   localparam int K_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int V_W      = $clog2(DEPTH + 1);
   localparam int C_W      = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int RD_WORDS = (CODE_W + 31) / 32;
   localparam int RI_W     = (RD_WORDS > 1) ? $clog2(RD_WORDS) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]        rState;
   logic [PIX_W-1:0]  rPix [N];
   logic [CODE_W-1:0] rRef;
   logic [CODE_W-1:0] rBuf [DEPTH];
   logic [V_W-1:0]    rValid;
   logic [K_W-1:0]    rK, rLastK, rBestK;
   logic [C_W-1:0]    rChunk;
   logic [ACC_W-1:0]  rAcc, rBestCost;
   logic              rIsMatch;

   logic [63:0]        pushWord;
   logic [NP_W-1:0]    nPush;
   logic [PIX_W-1:0]   push64Pix [N];
   logic [PIX_W-1:0]   pushNPix [N];
   logic [PIX_W-1:0]   codePix [CODE_W];
   logic [CODE_W-1:0]  code;
   logic [SCAN_W-1:0]  diff;
   logic [CHUNK-1:0]   chunks [NCH];
   logic [ACC_W-1:0]   costNow;
   logic               better, lastChunk, lastK;
   logic [32*RD_WORDS-1:0] refPad;
   logic [31:0]        refWords [RD_WORDS];
   logic [31:0]        rdData;

   assign pushWord = {iB, iA};
   assign nPush    = (iB[3:0] > 4'(PP32)) ? NP_W'(PP32) : NP_W'(iB[3:0]);

   // Next-window candidates: each pixel muxes between staying put, a shifted neighbour or a new operand pixel.
   for (genvar i = 0; i < N; i++) begin : gWin
      logic [PIX_W-1:0] cand [PP32+1];
      if (i < PP64) begin : gLow
         assign push64Pix[i] = pushWord[i*PIX_W +: PIX_W];
      end else begin : gHigh
         assign push64Pix[i] = rPix[i-PP64];
      end
      assign cand[0] = rPix[i];
      for (genvar s = 1; s <= PP32; s++) begin : gSh
         if (i < s) begin : gIns
            assign cand[s] = iA[i*PIX_W +: PIX_W];
         end else begin : gMove
            assign cand[s] = rPix[i-s];
         end
      end
      assign pushNPix[i] = cand[nPush];
   end

   for (genvar b = 0; b < CODE_W; b++) begin : gCode
      if (b < HALF) begin : gBelow
         assign codePix[b] = rPix[b];
      end else begin : gAbove
         assign codePix[b] = rPix[b+1];
      end
   end

`ifdef CENSUS_THRESH_EN
   always_comb begin
      logic [PIX_W:0] sum;
      code = '0;
      for (int b = 0; b < CODE_W; b++) begin
         sum     = {1'b0, codePix[b]} + {1'b0, iB[PIX_W-1:0]};
         code[b] = (sum[PIX_W] ? {PIX_W{1'b1}} : sum[PIX_W-1:0]) < rPix[HALF];
      end
   end
`else
   always_comb begin
      code = '0;
      for (int b = 0; b < CODE_W; b++) code[b] = codePix[b] < rPix[HALF];
   end
`endif

   function automatic logic [ACC_W-1:0] popCount(input logic [CHUNK-1:0] v);
      logic [ACC_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < CHUNK; i++) cnt = cnt + ACC_W'(v[i]);
      return cnt;
   endfunction

   assign diff = SCAN_W'(rRef ^ rBuf[rK]);
   for (genvar c = 0; c < NCH; c++) begin : gChunk
      assign chunks[c] = diff[c*CHUNK +: CHUNK];
   end
   assign costNow   = rAcc + popCount(chunks[rChunk]);
   assign better    = costNow < rBestCost;
   assign lastChunk = (rChunk == C_W'(NCH - 1));
   assign lastK     = (rK == rLastK);

   assign refPad = (32*RD_WORDS)'(rRef);
   for (genvar w = 0; w < RD_WORDS; w++) begin : gRd
      assign refWords[w] = refPad[w*32 +: 32];
   end
   assign rdData = (iA < 32'(RD_WORDS)) ? refWords[iA[RI_W-1:0]] : 32'h0;

   // NOTE: window and candidate buffer are reset explicitly because their reset contents are visible to software.
   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         rState    <= IDLE;
         oRes      <= '0;
         oDone     <= 1'b0;
         rRef      <= '0;
         rValid    <= '0;
         rK        <= '0;
         rLastK    <= '0;
         rBestK    <= '0;
         rChunk    <= '0;
         rAcc      <= '0;
         rBestCost <= '1;
         rIsMatch  <= 1'b0;
         for (int i = 0; i < N; i++) rPix[i] <= '1;
         for (int k = 0; k < DEPTH; k++) rBuf[k] <= '0;
      end else if (iClk_en) begin
         case (rState)
            IDLE: if (iStart) begin
               rState    <= DONE;
               oDone     <= 1'b1;
               rK        <= '0;
               rChunk    <= '0;
               rAcc      <= '0;
               rBestCost <= '1;
               rBestK    <= '0;
               case (iOp)
                  4'd0: begin
                     for (int i = 0; i < N; i++) rPix[i] <= '1;
                     rValid <= '0;
                     rRef   <= '0;
                     oRes   <= '0;
                  end
                  4'd1: for (int i = 0; i < N; i++) rPix[i] <= push64Pix[i];
                  4'd2: for (int i = 0; i < N; i++) rPix[i] <= pushNPix[i];
                  4'd3: begin
                     if (iA[0]) begin
                        for (int k = 1; k < DEPTH; k++) rBuf[k] <= rBuf[k-1];
                        rBuf[0] <= code;
                        if (rValid != V_W'(DEPTH)) rValid <= rValid + 1'b1;
                     end else begin
                        rRef <= code;
                     end
                     oRes <= '0;
                  end
                  4'd4: begin
                     if (rValid == '0) begin
                        oRes <= 32'h0000_FFFF;
                     end else begin
                        rState   <= SCAN;
                        oDone    <= 1'b0;
                        rIsMatch <= 1'b1;
                        rLastK   <= K_W'(rValid - 1'b1);
                     end
                  end
                  4'd5: begin
                     if (iA >= 32'(DEPTH)) begin
                        oRes <= 32'hFFFF_FFFF;
                     end else begin
                        rState   <= SCAN;
                        oDone    <= 1'b0;
                        rIsMatch <= 1'b0;
                        rK       <= iA[K_W-1:0];
                        rLastK   <= iA[K_W-1:0];
                     end
                  end
                  4'd6: oRes <= rdData;
                  default: ;
               endcase
            end
            SCAN: begin
               if (!lastChunk) begin
                  rChunk <= rChunk + 1'b1;
                  rAcc   <= costNow;
               end else begin
                  rChunk <= '0;
                  rAcc   <= '0;
                  if (better) begin
                     rBestCost <= costNow;
                     rBestK    <= rK;
                  end
                  // Strict < keeps the lowest k on cost ties.
                  if (lastK) begin
                     rState <= DONE;
                     oDone  <= 1'b1;
                     oRes   <= rIsMatch ? {16'(better ? rK : rBestK), 16'(better ? costNow : rBestCost)}
                                        : 32'(costNow);
                  end else begin
                     rK <= rK + 1'b1;
                  end
               end
            end
            DONE: begin
               rState <= IDLE;
               oDone  <= 1'b0;
            end
            default: begin
               rState <= IDLE;
               oDone  <= 1'b0;
            end
         endcase
      end
   end

endmodule
